mag_i2c_target_model: RTL and testbench

- Synthesizable I2C target that emulates the MMC34160PJ magnetometer at the far end of the I2C bus.
- Lets the magnetometer polling path and downstream heading logic run in simulation, or on a second Pmod header for hardware-in-loop, without the real sensor.
- Samples externally supplied unsigned offset-binary X/Y/Z words on a measurement command and serves them through the sensor's register map.
- Oversamples SCL/SDA on the 100 MHz system clock. No clock stretching.

---
 rtl/mag_i2c_target_model.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_mag_i2c_target_model.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mag_i2c_target_model.sv
// I2C target emulating the MMC34160PJ magnetometer register map.
// SCL/SDA are oversampled on clk; sda is only ever pulled low or released.
module mag_i2c_target_model #(
  parameter logic [6:0]  I2C_ADDR    = 7'h30,
  parameter int unsigned MEAS_CYCLES = 50000,
  parameter logic [7:0]  PRODUCT_ID  = 8'h06
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] mag_x_in,
  input  logic [15:0] mag_y_in,
  input  logic [15:0] mag_z_in,
  output logic        busy,
  output logic        meas_done,
  output logic [7:0]  nack_count
);

  localparam int CW = $clog2(MEAS_CYCLES + 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_ACK_A  = 4'd2,
    ST_PTR    = 4'd3,
    ST_ACK_P  = 4'd4,
    ST_WR     = 4'd5,
    ST_ACK_W  = 4'd6,
    ST_RD     = 4'd7,
    ST_RACK   = 4'd8,
    ST_IGNORE = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_sync_q, scl_sync_d;
  logic [2:0]  sda_sync_q, sda_sync_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  nack_q, nack_d;
  logic        meas_run_q, meas_run_d;
  logic [CW-1:0] meas_cnt_q, meas_cnt_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_z_q, pend_z_d;
  logic [15:0] data_x_q, data_x_d, data_y_q, data_y_d, data_z_q, data_z_d;
  logic        done_q, done_d;
  logic [7:0]  ctrl1_q, ctrl1_d;

  logic        scl_rise_s, scl_fall_s, start_s, stop_s, sda_s;
  logic        wr_en_s, meas_start_s, expire_s;
  logic [7:0]  rd_byte_s;

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign busy       = busy_q;
  assign meas_done  = done_q;
  assign nack_count = nack_q;

  assign scl_sync_d = {scl_sync_q[1:0], scl};
  assign sda_sync_d = {sda_sync_q[1:0], sda};
  assign sda_s      = sda_sync_q[1];
  assign scl_rise_s = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall_s = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_s    = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] & sda_sync_q[2];
  assign stop_s     = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[1] & ~sda_sync_q[2];

  // Register read mux at the current pointer.
  always_comb begin
    rd_byte_s = 8'h00;
    case (ptr_q)
      8'h00:   rd_byte_s = data_x_q[7:0];
      8'h01:   rd_byte_s = data_x_q[15:8];
      8'h02:   rd_byte_s = data_y_q[7:0];
      8'h03:   rd_byte_s = data_y_q[15:8];
      8'h04:   rd_byte_s = data_z_q[7:0];
      8'h05:   rd_byte_s = data_z_q[15:8];
      8'h06:   rd_byte_s = {7'b0000000, done_q};
      8'h07:   rd_byte_s = {7'b0000000, meas_run_q};
      8'h08:   rd_byte_s = ctrl1_q;
      8'h20:   rd_byte_s = PRODUCT_ID;
      default: rd_byte_s = 8'h00;
    endcase
  end

  // Bus protocol state machine: START/STOP override every state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    nack_d    = nack_q;
    wr_en_s   = 1'b0;
    if (start_s) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_s) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR: begin
          if (scl_rise_s) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            case (state_q)
              ST_ADDR: begin
                if (shift_q[7:1] == I2C_ADDR) begin
                  state_d  = ST_ACK_A;
                  sda_oe_d = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                  nack_d  = (nack_q == 8'hFF) ? nack_q : nack_q + 8'd1;
                end
              end
              ST_PTR: begin
                ptr_d    = shift_q;
                sda_oe_d = 1'b1;
                state_d  = ST_ACK_P;
              end
              default: begin
                wr_en_s  = 1'b1;
                ptr_d    = ptr_q + 8'd1;
                sda_oe_d = 1'b1;
                state_d  = ST_ACK_W;
              end
            endcase
          end else begin
            state_d = state_q;
          end
        end
        ST_ACK_A: begin
          if (scl_fall_s) begin
            bit_cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d  = ST_RD;
              tx_d     = rd_byte_s;
              sda_oe_d = ~rd_byte_s[7];
              ptr_d    = ptr_q + 8'd1;
            end else begin
              state_d  = ST_PTR;
              sda_oe_d = 1'b0;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_ACK_P, ST_ACK_W: begin
          if (scl_fall_s) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            state_d   = ST_WR;
          end else begin
            state_d = state_q;
          end
        end
        ST_RD: begin
          if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            state_d   = ST_RACK;
          end else if (scl_fall_s && (bit_cnt_q != 4'd0)) begin
            tx_d     = {tx_q[6:0], 1'b0};
            sda_oe_d = ~tx_q[6];
          end else begin
            state_d = state_q;
          end
        end
        ST_RACK: begin
          // shift_q[0] holds the initiator's ACK bit sampled on the 9th rise.
          if (scl_rise_s) begin
            shift_d = {shift_q[6:0], sda_s};
          end else if (scl_fall_s) begin
            bit_cnt_d = 4'd0;
            if (!shift_q[0]) begin
              state_d  = ST_RD;
              tx_d     = rd_byte_s;
              sda_oe_d = ~rd_byte_s[7];
              ptr_d    = ptr_q + 8'd1;
            end else begin
              state_d  = ST_IGNORE;
              sda_oe_d = 1'b0;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_IDLE, ST_IGNORE: state_d = state_q;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign meas_start_s = wr_en_s && (ptr_q == 8'h07) && shift_q[0] && !meas_run_q && !pend_q;
  assign expire_s     = meas_run_q && (meas_cnt_q == CW'(MEAS_CYCLES - 1));

  // Measurement timer, pending buffer and deferred commit while the bus is busy.
  always_comb begin
    meas_run_d = meas_run_q;
    meas_cnt_d = meas_cnt_q;
    pend_d     = pend_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    pend_z_d   = pend_z_q;
    data_x_d   = data_x_q;
    data_y_d   = data_y_q;
    data_z_d   = data_z_q;
    done_d     = done_q;
    ctrl1_d    = ctrl1_q;
    if (wr_en_s && (ptr_q == 8'h08)) begin
      ctrl1_d = shift_q;
    end else begin
      ctrl1_d = ctrl1_q;
    end
    if (meas_start_s) begin
      meas_run_d = 1'b1;
      meas_cnt_d = '0;
      done_d     = 1'b0;
    end else if (expire_s) begin
      meas_run_d = 1'b0;
      meas_cnt_d = '0;
    end else if (meas_run_q) begin
      meas_cnt_d = meas_cnt_q + CW'(1);
    end else begin
      meas_cnt_d = meas_cnt_q;
    end
    if ((expire_s || pend_q) && !busy_d) begin
      data_x_d = expire_s ? mag_x_in : pend_x_q;
      data_y_d = expire_s ? mag_y_in : pend_y_q;
      data_z_d = expire_s ? mag_z_in : pend_z_q;
      done_d   = 1'b1;
      pend_d   = 1'b0;
    end else if (expire_s) begin
      pend_d   = 1'b1;
      pend_x_d = mag_x_in;
      pend_y_d = mag_y_in;
      pend_z_d = mag_z_in;
    end else begin
      pend_d = pend_q;
    end
  end

  // State registers with synchronous reset; synchronizers idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      tx_q       <= 8'h00;
      ptr_q      <= 8'h00;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 8'h00;
      meas_run_q <= 1'b0;
      meas_cnt_q <= '0;
      pend_q     <= 1'b0;
      pend_x_q   <= 16'h0000;
      pend_y_q   <= 16'h0000;
      pend_z_q   <= 16'h0000;
      data_x_q   <= 16'h0000;
      data_y_q   <= 16'h0000;
      data_z_q   <= 16'h0000;
      done_q     <= 1'b0;
      ctrl1_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
      meas_run_q <= meas_run_d;
      meas_cnt_q <= meas_cnt_d;
      pend_q     <= pend_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pend_z_q   <= pend_z_d;
      data_x_q   <= data_x_d;
      data_y_q   <= data_y_d;
      data_z_q   <= data_z_d;
      done_q     <= done_d;
      ctrl1_q    <= ctrl1_d;
    end
  end

endmodule

// File: tb/tb_mag_i2c_target_model.sv
// Directed bench for mag_i2c_target_model: a bit-banged I2C initiator with
// expected read bytes queued on issue and popped as each byte arrives.
module tb_mag_i2c_target_model;

  localparam int MEAS = 2000;
  localparam int Q    = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        scl;
  logic        m_sda_lo;
  logic [15:0] mag_x_in, mag_y_in, mag_z_in;
  logic        busy, meas_done;
  logic [7:0]  nack_count;
  wire         sda;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] exp_q[$];

  assign sda = m_sda_lo ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  mag_i2c_target_model #(
    .I2C_ADDR(7'h30), .MEAS_CYCLES(MEAS), .PRODUCT_ID(8'h06)
  ) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .mag_x_in(mag_x_in), .mag_y_in(mag_y_in), .mag_z_in(mag_z_in),
    .busy(busy), .meas_done(meas_done), .nack_count(nack_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_lo = 1'b0; wait_clk(Q);
    scl = 1'b1;      wait_clk(Q);
    m_sda_lo = 1'b1; wait_clk(Q);
    scl = 1'b0;      wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda_lo = 1'b1; wait_clk(Q);
    scl = 1'b1;      wait_clk(Q);
    m_sda_lo = 1'b0; wait_clk(Q);
  endtask

  task automatic wr_bit(input logic b);
    m_sda_lo = ~b; wait_clk(Q);
    scl = 1'b1;    wait_clk(2 * Q);
    scl = 1'b0;    wait_clk(Q);
  endtask

  task automatic rd_bit(output logic b);
    m_sda_lo = 1'b0; wait_clk(Q);
    scl = 1'b1;      wait_clk(Q);
    b = sda;         wait_clk(Q);
    scl = 1'b0;      wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(v[i]);
    rd_bit(ack);
  endtask

  task automatic rd_byte(input string tag, input logic do_ack);
    logic [7:0] v;
    logic       b;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      v[i] = b;
    end
    wr_bit(~do_ack);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {8'h00, v}, {8'h00, e});
    end
  endtask

  task automatic reg_write(input logic [7:0] ptr, input logic [7:0] data);
    logic ack;
    i2c_start();
    wr_byte({7'h30, 1'b0}, ack); chk("wr_addr_ack", {15'd0, ack}, 16'd0);
    wr_byte(ptr, ack);           chk("wr_ptr_ack",  {15'd0, ack}, 16'd0);
    wr_byte(data, ack);          chk("wr_data_ack", {15'd0, ack}, 16'd0);
    i2c_stop();
  endtask

  // Sets the pointer, repeated START, reads n bytes with NACK on the last.
  task automatic reg_read(input string tag, input logic [7:0] ptr, input int n);
    logic ack;
    i2c_start();
    wr_byte({7'h30, 1'b0}, ack); chk("rd_waddr_ack", {15'd0, ack}, 16'd0);
    wr_byte(ptr, ack);           chk("rd_ptr_ack",   {15'd0, ack}, 16'd0);
    i2c_start();
    wr_byte({7'h30, 1'b1}, ack); chk("rd_raddr_ack", {15'd0, ack}, 16'd0);
    for (int i = 0; i < n; i++) rd_byte(tag, (i != n - 1));
    wait_clk(4);
    chk({tag, "_sda_rel_after_nack"}, {15'd0, sda}, 16'd1);
    chk({tag, "_busy_in_xfer"}, {15'd0, busy}, 16'd1);
    i2c_stop();
    wait_clk(2);
    chk({tag, "_busy_after_stop"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    logic ack;
    reset = 1'b1; scl = 1'b1; m_sda_lo = 1'b0;
    mag_x_in = 16'h8000; mag_y_in = 16'h8000; mag_z_in = 16'h8000;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(5);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_meas_done", {15'd0, meas_done}, 16'd0);
    chk("rst_nack_count", {8'd0, nack_count}, 16'd0);
    chk("rst_sda", {15'd0, sda}, 16'd1);
    exp_q.push_back(8'h00);
    reg_read("rst_data_x_lsb", 8'h00, 1);

    // Measurement: status reads running bit, then Meas_Done after expiry.
    mag_x_in = 16'h8123; mag_y_in = 16'h7F45; mag_z_in = 16'h8000;
    reg_write(8'h07, 8'h01);
    exp_q.push_back(8'h01);
    reg_read("ctrl0_running", 8'h07, 1);
    wait_clk(MEAS + 20);
    chk("meas_done_set", {15'd0, meas_done}, 16'd1);
    exp_q.push_back(8'h01);
    reg_read("status", 8'h06, 1);
    exp_q.push_back(8'h00);
    reg_read("ctrl0_idle", 8'h07, 1);

    // Six-byte burst of X/Y/Z.
    foreach (exp_q[i]) chk("sb_drained", 16'd1, 16'd0);
    exp_q.push_back(8'h23); exp_q.push_back(8'h81);
    exp_q.push_back(8'h45); exp_q.push_back(8'h7F);
    exp_q.push_back(8'h00); exp_q.push_back(8'h80);
    reg_read("burst", 8'h00, 6);

    // Address mismatch, then normal traffic to 0x30.
    i2c_start();
    wr_byte({7'h31, 1'b0}, ack);
    chk("bad_addr_nack", {15'd0, ack}, 16'd1);
    chk("nack_count_1", {8'd0, nack_count}, 16'd1);
    i2c_stop();
    reg_write(8'h08, 8'h5A);
    exp_q.push_back(8'h5A);
    reg_read("ctrl1", 8'h08, 1);
    exp_q.push_back(8'h06);
    reg_read("product_id", 8'h20, 1);
    exp_q.push_back(8'h00);
    reg_read("unmapped", 8'h21, 1);

    // Measurement completes mid-burst: burst keeps old bytes, commit after STOP.
    reg_write(8'h07, 8'h01);
    mag_x_in = 16'hA5A5;
    exp_q.push_back(8'h23); exp_q.push_back(8'h81);
    i2c_start();
    wr_byte({7'h30, 1'b0}, ack); chk("def_waddr_ack", {15'd0, ack}, 16'd0);
    wr_byte(8'h00, ack);         chk("def_ptr_ack",   {15'd0, ack}, 16'd0);
    i2c_start();
    wr_byte({7'h30, 1'b1}, ack); chk("def_raddr_ack", {15'd0, ack}, 16'd0);
    rd_byte("deferred_b0", 1'b1);
    wait_clk(MEAS + 20);
    chk("deferred_done_low", {15'd0, meas_done}, 16'd0);
    rd_byte("deferred_b1", 1'b0);
    i2c_stop();
    wait_clk(3);
    chk("deferred_done_after_stop", {15'd0, meas_done}, 16'd1);
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    reg_read("new_x", 8'h00, 2);

    // Reset while the target is pulling sda low in a read data bit.
    i2c_start();
    wr_byte({7'h30, 1'b0}, ack); chk("rst_waddr_ack", {15'd0, ack}, 16'd0);
    wr_byte(8'h20, ack);         chk("rst_ptr_ack",   {15'd0, ack}, 16'd0);
    i2c_start();
    wr_byte({7'h30, 1'b1}, ack); chk("rst_raddr_ack", {15'd0, ack}, 16'd0);
    chk("sda_driven_low", {15'd0, sda}, 16'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("sda_released_on_reset", {15'd0, sda}, 16'd1);
    @(negedge clk);
    reset = 1'b0;
    i2c_stop();
    wait_clk(3);
    chk("post_rst_busy", {15'd0, busy}, 16'd0);
    chk("post_rst_nack_count", {8'd0, nack_count}, 16'd0);
    exp_q.push_back(8'h00);
    reg_read("post_rst_status", 8'h06, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
